// File: rtl/asteroids_pkg.sv
// Shared types and widths for the asteroid game-side control logic.
package asteroids_pkg;
  localparam int SCORE_W = 14;
  localparam int LIVES_W = 2;
  typedef enum logic [1:0] {IDLE, ARMED, RESPAWN, GAME_OVER} state_t;
endpackage

// File: rtl/frame_counter.sv
// 8-bit frame down-counter: loaded by a pulse, decremented on vsync, stops at zero.
module frame_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       vsync,
  output logic [7:0] count
);
  logic [7:0] count_reg;

  // A load on a vsync cycle wins so the full frame count is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= 8'd0;
    else if (clr)
      count_reg <= 8'd0;
    else if (load)
      count_reg <= load_val;
    else if (vsync && count_reg != 8'd0)
      count_reg <= count_reg - 8'd1;
  end

  assign count = count_reg;
endmodule

// File: rtl/asteroid_hit_ctrl.sv
// Per-frame overlap detection, asteroid hit/respawn sequencing, score and lives tracking.
module asteroid_hit_ctrl
  import asteroids_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int SMALL_POINTS   = 100,
  parameter int SCORE_MAX      = 9999,
  parameter int LIVES          = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_done,
  input  logic               vsync,
  input  logic               pix_valid,
  input  logic               ast_pixel,
  input  logic               torpedo_pixel,
  input  logic               ship_pixel,
  input  logic [6:0]         ast_points,
  output logic               asteroid_hit,
  output logic               new_asteroid,
  output logic               torpedo_kill,
  output logic               ship_crash,
  output logic               ast_draw_mask,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);
  localparam logic [SCORE_W:0]   SCORE_MAX_W = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
  localparam logic [6:0]         SMALL_PTS   = 7'(SMALL_POINTS);

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [LIVES_W-1:0] lives_reg, lives_next;
  logic               hit_f_reg, hit_f_next;
  logic               crash_f_reg, crash_f_next;
  logic               hit_pulse_reg, hit_pulse_next;
  logic               new_pulse_reg, new_pulse_next;
  logic               crash_pulse_reg, crash_pulse_next;
  logic               resp_load, inv_load;
  logic [7:0]         resp_count, inv_count;
  logic               hit_now, crash_now;
  logic [SCORE_W:0]   score_sum;

  frame_counter u_respawn (
    .clk(clk), .rst(rst), .clr(!start_done), .load(resp_load),
    .load_val(8'(RESPAWN_FRAMES)), .vsync(vsync), .count(resp_count)
  );

  frame_counter u_invuln (
    .clk(clk), .rst(rst), .clr(!start_done), .load(inv_load),
    .load_val(8'(INVULN_FRAMES)), .vsync(vsync), .count(inv_count)
  );

  assign hit_now   = pix_valid && ast_pixel && torpedo_pixel;
  assign crash_now = pix_valid && ast_pixel && ship_pixel;
  assign score_sum = {1'b0, score_reg} + (SCORE_W+1)'(ast_points);

  assign ast_draw_mask = (state_reg != RESPAWN);
  assign game_over     = (state_reg == GAME_OVER);
  assign asteroid_hit  = hit_pulse_reg;
  assign torpedo_kill  = hit_pulse_reg;
  assign new_asteroid  = new_pulse_reg;
  assign ship_crash    = crash_pulse_reg;
  assign score         = score_reg;
  assign lives         = lives_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      score_reg       <= '0;
      lives_reg       <= LIVES_INIT;
      hit_f_reg       <= 1'b0;
      crash_f_reg     <= 1'b0;
      hit_pulse_reg   <= 1'b0;
      new_pulse_reg   <= 1'b0;
      crash_pulse_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      score_reg       <= score_next;
      lives_reg       <= lives_next;
      hit_f_reg       <= hit_f_next;
      crash_f_reg     <= crash_f_next;
      hit_pulse_reg   <= hit_pulse_next;
      new_pulse_reg   <= new_pulse_next;
      crash_pulse_reg <= crash_pulse_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    score_next       = score_reg;
    lives_next       = lives_reg;
    hit_pulse_next   = 1'b0;
    new_pulse_next   = 1'b0;
    crash_pulse_next = 1'b0;
    resp_load        = 1'b0;
    inv_load         = 1'b0;
    // An overlap seen on the vsync cycle itself seeds the next frame's flag.
    hit_f_next   = vsync ? hit_now   : (hit_f_reg   || hit_now);
    crash_f_next = vsync ? crash_now : (crash_f_reg || crash_now);

    if (!start_done) begin
      state_next = IDLE;
      score_next = '0;
      lives_next = LIVES_INIT;
    end else begin
      case (state_reg)
        IDLE: begin
          score_next = '0;
          lives_next = LIVES_INIT;
          if (vsync) begin
            new_pulse_next = 1'b1;
            state_next     = ARMED;
          end
        end
        ARMED: begin
          if (vsync && hit_f_reg) begin
            hit_pulse_next = 1'b1;
            score_next     = (score_sum > SCORE_MAX_W) ? SCORE_MAX_W[SCORE_W-1:0]
                                                       : score_sum[SCORE_W-1:0];
            if (ast_points == SMALL_PTS) begin
              state_next = RESPAWN;
              resp_load  = 1'b1;
            end
          end
        end
        RESPAWN: begin
          if (vsync && resp_count == 8'd1) begin
            new_pulse_next = 1'b1;
            state_next     = ARMED;
          end
        end
        default: ;
      endcase

      // Crash handling runs after the hit logic so GAME_OVER overrides RESPAWN.
      if ((state_reg == ARMED || state_reg == RESPAWN) && ast_draw_mask &&
          inv_count == 8'd0 && vsync && crash_f_reg) begin
        crash_pulse_next = 1'b1;
        inv_load         = 1'b1;
        if (lives_reg <= 2'd1) begin
          lives_next = '0;
          state_next = GAME_OVER;
        end else begin
          lives_next = lives_reg - 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_asteroid_hit_ctrl.sv
// Directed-vector bench for asteroid_hit_ctrl with hand-computed expectations.
module tb_asteroid_hit_ctrl;
  logic        clk = 1'b0;
  logic        rst, start_done, vsync, pix_valid, ast_pixel, torpedo_pixel, ship_pixel;
  logic [6:0]  ast_points;
  logic        asteroid_hit, new_asteroid, torpedo_kill, ship_crash, ast_draw_mask, game_over;
  logic [13:0] score;
  logic [1:0]  lives;
  int          total = 0;
  int          bad   = 0;

  asteroid_hit_ctrl #(
    .RESPAWN_FRAMES(3), .INVULN_FRAMES(2), .SMALL_POINTS(100), .SCORE_MAX(9999), .LIVES(3)
  ) dut (
    .clk(clk), .rst(rst), .start_done(start_done), .vsync(vsync), .pix_valid(pix_valid),
    .ast_pixel(ast_pixel), .torpedo_pixel(torpedo_pixel), .ship_pixel(ship_pixel),
    .ast_points(ast_points), .asteroid_hit(asteroid_hit), .new_asteroid(new_asteroid),
    .torpedo_kill(torpedo_kill), .ship_crash(ship_crash), .ast_draw_mask(ast_draw_mask),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One 100-cycle frame ending in a vsync; returns just after the vsync edge.
  task automatic run_frame(input logic h, input logic c, input logic vs_h, input logic [6:0] pts);
    for (int i = 0; i < 99; i++) begin
      pix_valid     = (i == 50);
      ast_pixel     = (i == 50);
      torpedo_pixel = (i == 50) && h;
      ship_pixel    = (i == 50) && c;
      tick();
    end
    pix_valid = vs_h; ast_pixel = vs_h; torpedo_pixel = vs_h; ship_pixel = 1'b0;
    vsync = 1'b1; ast_points = pts;
    tick();
    vsync = 1'b0; pix_valid = 1'b0; ast_pixel = 1'b0; torpedo_pixel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_done = 1'b0; vsync = 1'b0; pix_valid = 1'b0;
    ast_pixel = 1'b0; torpedo_pixel = 1'b0; ship_pixel = 1'b0; ast_points = 7'd0;
    tick(); tick();
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_mask", 16'(ast_draw_mask), 16'd1);
    chk("rst_gameover", 16'(game_over), 16'd0);
    chk("rst_pulses", {12'd0, asteroid_hit, new_asteroid, torpedo_kill, ship_crash}, 16'd0);
    rst = 1'b0;
    start_done = 1'b1;
    $display("txn start");
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("start_new", 16'(new_asteroid), 16'd1);
    chk("start_lives", 16'(lives), 16'd3);
    tick();
    chk("start_new_1cyc", 16'(new_asteroid), 16'd0);

    $display("txn hit 20");
    run_frame(1'b1, 1'b0, 1'b0, 7'd20);
    chk("hit20_hit", 16'(asteroid_hit), 16'd1);
    chk("hit20_kill", 16'(torpedo_kill), 16'd1);
    chk("hit20_new", 16'(new_asteroid), 16'd0);
    chk("hit20_score", 16'(score), 16'd20);
    tick();
    chk("hit20_1cyc", 16'(asteroid_hit), 16'd0);

    $display("txn hit small");
    run_frame(1'b1, 1'b0, 1'b0, 7'd100);
    chk("small_hit", 16'(asteroid_hit), 16'd1);
    chk("small_score", 16'(score), 16'd120);
    chk("small_mask0", 16'(ast_draw_mask), 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("resp1_mask", 16'(ast_draw_mask), 16'd0);
    chk("resp1_new", 16'(new_asteroid), 16'd0);
    run_frame(1'b1, 1'b0, 1'b0, 7'd20);
    chk("resp2_hit_ignored", 16'(asteroid_hit), 16'd0);
    chk("resp2_score", 16'(score), 16'd120);
    chk("resp2_mask", 16'(ast_draw_mask), 16'd0);
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("resp3_new", 16'(new_asteroid), 16'd1);
    chk("resp3_mask", 16'(ast_draw_mask), 16'd1);

    $display("txn overlap on vsync only");
    run_frame(1'b0, 1'b0, 1'b1, 7'd20);
    chk("vsovl_now", 16'(asteroid_hit), 16'd0);
    chk("vsovl_score_now", 16'(score), 16'd120);
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("vsovl_next", 16'(asteroid_hit), 16'd1);
    chk("vsovl_score_next", 16'(score), 16'd140);

    $display("txn crashes");
    run_frame(1'b0, 1'b1, 1'b0, 7'd20);
    chk("crash1", 16'(ship_crash), 16'd1);
    chk("crash1_lives", 16'(lives), 16'd2);
    run_frame(1'b0, 1'b1, 1'b0, 7'd20);
    chk("crash2_invuln", 16'(ship_crash), 16'd0);
    run_frame(1'b0, 1'b1, 1'b0, 7'd20);
    chk("crash3_invuln", 16'(ship_crash), 16'd0);
    chk("crash3_lives", 16'(lives), 16'd2);
    run_frame(1'b0, 1'b1, 1'b0, 7'd20);
    chk("crash4", 16'(ship_crash), 16'd1);
    chk("crash4_lives", 16'(lives), 16'd1);
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    run_frame(1'b1, 1'b1, 1'b0, 7'd100);
    chk("last_crash", 16'(ship_crash), 16'd1);
    chk("last_hit", 16'(asteroid_hit), 16'd1);
    chk("last_score", 16'(score), 16'd240);
    chk("last_lives", 16'(lives), 16'd0);
    chk("last_gameover", 16'(game_over), 16'd1);
    chk("last_mask", 16'(ast_draw_mask), 16'd1);
    run_frame(1'b0, 1'b1, 1'b0, 7'd20);
    run_frame(1'b1, 1'b1, 1'b0, 7'd20);
    chk("go_no_crash", 16'(ship_crash), 16'd0);
    chk("go_no_hit", 16'(asteroid_hit), 16'd0);
    chk("go_held", 16'(game_over), 16'd1);

    $display("txn restart");
    start_done = 1'b0;
    tick();
    chk("idle_lives", 16'(lives), 16'd3);
    chk("idle_score", 16'(score), 16'd0);
    chk("idle_gameover", 16'(game_over), 16'd0);

    $display("txn saturation");
    start_done = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("restart_new", 16'(new_asteroid), 16'd1);
    for (int k = 0; k < 79; k++) run_frame(1'b1, 1'b0, 1'b0, 7'd126);
    run_frame(1'b1, 1'b0, 1'b0, 7'd36);
    chk("sat_9990", 16'(score), 16'd9990);
    run_frame(1'b1, 1'b0, 1'b0, 7'd50);
    chk("sat_clamp", 16'(score), 16'd9999);
    chk("sat_hit", 16'(asteroid_hit), 16'd1);
    run_frame(1'b1, 1'b0, 1'b0, 7'd20);
    chk("sat_hold", 16'(score), 16'd9999);

    $display("txn reset mid-frame");
    pix_valid = 1'b1; ast_pixel = 1'b1; torpedo_pixel = 1'b1; ship_pixel = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_score", 16'(score), 16'd0);
    chk("mid_rst_lives", 16'(lives), 16'd3);
    chk("mid_rst_hit", 16'(asteroid_hit), 16'd0);
    pix_valid = 1'b0; ast_pixel = 1'b0; torpedo_pixel = 1'b0; ship_pixel = 1'b0;
    #1 rst = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, 7'd20);
    chk("post_rst_new", 16'(new_asteroid), 16'd1);
    chk("post_rst_hit", 16'(asteroid_hit), 16'd0);
    chk("post_rst_crash", 16'(ship_crash), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
